ps2_command_decoder: RTL and testbench
======================================

PS2_COMMAND_DECODER -- requirements
Module: ps2_command_decoder

Interface
REQ-001 SHALL have parameter: ALLOW_REVERSE, default 1, 0 = ignore a make that requests the direction opposite to that player's current direction.
REQ-002 SHALL have port: clock  in  1  system clock (CLOCK_50 domain); one clock only.
REQ-003 SHALL have port: reset_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: ps2_code_new  in  1  receiver new-code flag; a rising edge marks a new byte.
REQ-005 SHALL have port: ps2_code  in  8  scancode byte, stable while ps2_code_new is high.
REQ-006 SHALL have ports: dir1, dir2, dir3, dir4  out  dir_t  registered per-player direction.
REQ-007 SHALL have port: player_count  out  3  registered active player count, 2..4.
REQ-008 SHALL have port: game_reset  out  1  registered single-cycle restart pulse to game_logic.

Function
REQ-009 SHALL register ps2_code_new into new_d1 then new_d2; event = new_d1 & ~new_d2; each event samples ps2_code once.
REQ-010 SHALL update outputs on the second rising clock edge after ps2_code_new is first sampled high (latency 2).
REQ-011 SHALL hold ps2_code_new high for many cycles as one event only.
REQ-012 SHALL implement FSM states IDLE, EXT, BREAK, EXT_BREAK, advanced only on events.
REQ-013 IDLE: E0 -> EXT; F0 -> BREAK; other byte -> make(code, ext=0), stay IDLE.
REQ-014 EXT: E0 -> stay; F0 -> EXT_BREAK; other byte -> make(code, ext=1) -> IDLE.
REQ-015 BREAK: E0 -> EXT_BREAK; F0 -> stay; other byte -> break(code, ext=0) -> IDLE.
REQ-016 EXT_BREAK: E0/F0 -> stay; other byte -> break(code, ext=1) -> IDLE.
REQ-017 Make (non-ext) SHALL map P1 1D/1B/1C/23, P3 2C/34/2B/33, P4 43/42/3B/4B to UP/DOWN/LEFT/RIGHT in that order.
REQ-018 Make (ext) SHALL map P2 75/72/6B/74 to UP/DOWN/LEFT/RIGHT.
REQ-019 A P1 code with ext=1, or a P2 code with ext=0, SHALL be ignored.
REQ-020 Make of 1E/26/25 (non-ext) SHALL set player_count to 2/3/4 and load the default directions (RIGHT, LEFT, DOWN, UP).
REQ-021 Make of 29 (non-ext) SHALL load the default directions and leave player_count unchanged.
REQ-022 Break of 29/1E/26/25 (non-ext) SHALL assert game_reset for exactly one cycle; all other breaks SHALL change nothing.
REQ-023 Make for P3 SHALL be ignored when player_count < 3; make for P4 SHALL be ignored when player_count < 4.
REQ-024 With ALLOW_REVERSE=0, a make requesting the opposite of the current dirN SHALL be ignored; a same-direction make SHALL be a no-op.
REQ-025 Unmapped codes SHALL change no output; the FSM SHALL follow REQ-013..016.
REQ-026 Events arriving on consecutive cycles SHALL each be processed in order; no event is dropped.

Reset
REQ-027 While reset_n is low: dir1=RIGHT, dir2=LEFT, dir3=DOWN, dir4=UP, player_count=4, game_reset=0, FSM=IDLE.
REQ-028 new_d1/new_d2 SHALL reset to 1, so a ps2_code_new already high at reset release produces no event.
REQ-029 Reset asserted mid-sequence (e.g. after E0) SHALL discard the prefix; the next byte is decoded from IDLE.

Structure
REQ-030 tron_types SHALL hold dir_t, the scancode constants (KEY_*, PREFIX_E0, PREFIX_F0) and the default-direction constants.
REQ-031 The FSM state enum SHALL be local to the module.
REQ-032 The block SHALL be a single module with no sub-module; it replaces the inline decode in tron.

Verification
REQ-033 Byte 1D -> dir1=UP exactly 2 cycles after the ps2_code_new rise; other outputs unchanged.
REQ-034 Bytes E0, 6B -> dir2=LEFT; bytes E0, F0, 6B -> no change and FSM back in IDLE; bare 6B -> dir2 unchanged.
REQ-035 Bytes 1E, F0, 1E -> player_count=2, default directions loaded, one game_reset pulse; then 2C -> dir3 unchanged.
REQ-036 With ALLOW_REVERSE=0, dir1=RIGHT, byte 1C -> dir1 stays RIGHT; then 1D -> UP.
REQ-037 Hold ps2_code_new high 50 cycles with 23 -> exactly one event; reset_n pulsed low after E0, then 74 -> treated as non-ext with no change.

Source files
------------

// File: rtl/tron_types.sv
`default_nettype none
// tron_types: shared direction type, PS/2 scancode constants and key-decode helpers.
// Rev 1.0 - initial release.
package tron_types;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   localparam logic [7:0] PREFIX_E0 = 8'hE0;
   localparam logic [7:0] PREFIX_F0 = 8'hF0;

   localparam logic [7:0] KEY_P1_UP    = 8'h1D;
   localparam logic [7:0] KEY_P1_DOWN  = 8'h1B;
   localparam logic [7:0] KEY_P1_LEFT  = 8'h1C;
   localparam logic [7:0] KEY_P1_RIGHT = 8'h23;

   localparam logic [7:0] KEY_P2_UP    = 8'h75;
   localparam logic [7:0] KEY_P2_DOWN  = 8'h72;
   localparam logic [7:0] KEY_P2_LEFT  = 8'h6B;
   localparam logic [7:0] KEY_P2_RIGHT = 8'h74;

   localparam logic [7:0] KEY_P3_UP    = 8'h2C;
   localparam logic [7:0] KEY_P3_DOWN  = 8'h34;
   localparam logic [7:0] KEY_P3_LEFT  = 8'h2B;
   localparam logic [7:0] KEY_P3_RIGHT = 8'h33;

   localparam logic [7:0] KEY_P4_UP    = 8'h43;
   localparam logic [7:0] KEY_P4_DOWN  = 8'h42;
   localparam logic [7:0] KEY_P4_LEFT  = 8'h3B;
   localparam logic [7:0] KEY_P4_RIGHT = 8'h4B;

   localparam logic [7:0] KEY_GAME_2P   = 8'h1E;
   localparam logic [7:0] KEY_GAME_3P   = 8'h26;
   localparam logic [7:0] KEY_GAME_4P   = 8'h25;
   localparam logic [7:0] KEY_RESTART   = 8'h29;

   localparam dir_t DEFAULT_DIR1 = DIR_RIGHT;
   localparam dir_t DEFAULT_DIR2 = DIR_LEFT;
   localparam dir_t DEFAULT_DIR3 = DIR_DOWN;
   localparam dir_t DEFAULT_DIR4 = DIR_UP;

   localparam logic [2:0] DEFAULT_PLAYER_COUNT = 3'd4;

   // player is zero-based: 0 = P1 .. 3 = P4
   typedef struct packed {
      logic       valid;
      logic [1:0] player;
      dir_t       dir;
   } steer_t;

   function automatic dir_t opposite_dir(input dir_t d);
      dir_t r;
      case (d)
         DIR_UP:    r = DIR_DOWN;
         DIR_DOWN:  r = DIR_UP;
         DIR_LEFT:  r = DIR_RIGHT;
         default:   r = DIR_LEFT;
      endcase
      return r;
   endfunction

   // Player 2 lives on the extended (E0-prefixed) arrow keys; everyone else is plain.
   function automatic steer_t decode_steer(input logic [7:0] code, input logic ext);
      steer_t s;
      s = '{valid: 1'b0, player: 2'd0, dir: DIR_UP};
      if (ext) begin
         case (code)
            KEY_P2_UP:    s = '{valid: 1'b1, player: 2'd1, dir: DIR_UP};
            KEY_P2_DOWN:  s = '{valid: 1'b1, player: 2'd1, dir: DIR_DOWN};
            KEY_P2_LEFT:  s = '{valid: 1'b1, player: 2'd1, dir: DIR_LEFT};
            KEY_P2_RIGHT: s = '{valid: 1'b1, player: 2'd1, dir: DIR_RIGHT};
            default:      s.valid = 1'b0;
         endcase
      end else begin
         case (code)
            KEY_P1_UP:    s = '{valid: 1'b1, player: 2'd0, dir: DIR_UP};
            KEY_P1_DOWN:  s = '{valid: 1'b1, player: 2'd0, dir: DIR_DOWN};
            KEY_P1_LEFT:  s = '{valid: 1'b1, player: 2'd0, dir: DIR_LEFT};
            KEY_P1_RIGHT: s = '{valid: 1'b1, player: 2'd0, dir: DIR_RIGHT};
            KEY_P3_UP:    s = '{valid: 1'b1, player: 2'd2, dir: DIR_UP};
            KEY_P3_DOWN:  s = '{valid: 1'b1, player: 2'd2, dir: DIR_DOWN};
            KEY_P3_LEFT:  s = '{valid: 1'b1, player: 2'd2, dir: DIR_LEFT};
            KEY_P3_RIGHT: s = '{valid: 1'b1, player: 2'd2, dir: DIR_RIGHT};
            KEY_P4_UP:    s = '{valid: 1'b1, player: 2'd3, dir: DIR_UP};
            KEY_P4_DOWN:  s = '{valid: 1'b1, player: 2'd3, dir: DIR_DOWN};
            KEY_P4_LEFT:  s = '{valid: 1'b1, player: 2'd3, dir: DIR_LEFT};
            KEY_P4_RIGHT: s = '{valid: 1'b1, player: 2'd3, dir: DIR_RIGHT};
            default:      s.valid = 1'b0;
         endcase
      end
      return s;
   endfunction

   function automatic logic is_game_key(input logic [7:0] code);
      return (code == KEY_GAME_2P) || (code == KEY_GAME_3P) ||
             (code == KEY_GAME_4P) || (code == KEY_RESTART);
   endfunction

   function automatic logic player_active(input logic [1:0] player, input logic [2:0] count);
      logic r;
      case (player)
         2'd2:    r = (count >= 3'd3);
         2'd3:    r = (count >= 3'd4);
         default: r = 1'b1;
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_command_decoder_if.sv
`default_nettype none
// ps2_command_decoder_if: scancode input and game-control outputs of the keyboard decoder.
// Rev 1.0 - initial release.
interface ps2_command_decoder_if;
   import tron_types::*;

   logic       ps2_code_new;
   logic [7:0] ps2_code;
   dir_t       dir1;
   dir_t       dir2;
   dir_t       dir3;
   dir_t       dir4;
   logic [2:0] player_count;
   logic       game_reset;

   modport master (
      output ps2_code_new,
      output ps2_code,
      input  dir1,
      input  dir2,
      input  dir3,
      input  dir4,
      input  player_count,
      input  game_reset
   );

   modport slave (
      input  ps2_code_new,
      input  ps2_code,
      output dir1,
      output dir2,
      output dir3,
      output dir4,
      output player_count,
      output game_reset
   );

endinterface
`default_nettype wire

// File: rtl/ps2_command_decoder.sv
`default_nettype none
// ps2_command_decoder: turns PS/2 make/break scancodes into per-player directions,
// player count and a game restart pulse. Rev 1.0 - initial release.
module ps2_command_decoder
   import tron_types::*;
#(
   parameter int unsigned ALLOW_REVERSE = 1
)
(
   input  wire logic              clock,
   input  wire logic              reset_n,
   ps2_command_decoder_if.slave   ps2_bus
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_EXT       = 2'd1,
      ST_BREAK     = 2'd2,
      ST_EXT_BREAK = 2'd3
   } state_t;

   logic       r_new_d1;
   logic       r_new_d2;
   logic [7:0] r_code_d1;
   logic       w_event;

   state_t     r_state;
   state_t     w_state_next;
   logic       w_is_make;
   logic       w_is_break;
   logic       w_is_ext;

   dir_t       r_dir [4];
   dir_t       w_dir_next [4];
   logic [2:0] r_count;
   logic [2:0] w_count_next;
   logic       r_game_reset;
   logic       w_game_reset_next;
   steer_t     w_steer;
   logic       w_steer_ok;

   // Code is captured alongside the flag so a one-cycle pulse still decodes correctly.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_new_d1  <= 1'b1;
         r_new_d2  <= 1'b1;
         r_code_d1 <= 8'h00;
      end else begin
         r_new_d1  <= ps2_bus.ps2_code_new;
         r_new_d2  <= r_new_d1;
         r_code_d1 <= ps2_bus.ps2_code;
      end
   end

   assign w_event = r_new_d1 & ~r_new_d2;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_is_make    = 1'b0;
      w_is_break   = 1'b0;
      w_is_ext     = 1'b0;
      if (w_event) begin
         case (r_state)
            ST_IDLE: begin
               if (r_code_d1 == PREFIX_E0) begin
                  w_state_next = ST_EXT;
               end else if (r_code_d1 == PREFIX_F0) begin
                  w_state_next = ST_BREAK;
               end else begin
                  w_is_make = 1'b1;
               end
            end
            ST_EXT: begin
               if (r_code_d1 == PREFIX_F0) begin
                  w_state_next = ST_EXT_BREAK;
               end else if (r_code_d1 != PREFIX_E0) begin
                  w_is_make    = 1'b1;
                  w_is_ext     = 1'b1;
                  w_state_next = ST_IDLE;
               end
            end
            ST_BREAK: begin
               if (r_code_d1 == PREFIX_E0) begin
                  w_state_next = ST_EXT_BREAK;
               end else if (r_code_d1 != PREFIX_F0) begin
                  w_is_break   = 1'b1;
                  w_state_next = ST_IDLE;
               end
            end
            ST_EXT_BREAK: begin
               if ((r_code_d1 != PREFIX_E0) && (r_code_d1 != PREFIX_F0)) begin
                  w_is_break   = 1'b1;
                  w_is_ext     = 1'b1;
                  w_state_next = ST_IDLE;
               end
            end
            default: begin
               w_state_next = ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      for (int p = 0; p < 4; p++) begin
         w_dir_next[p] = r_dir[p];
      end
      w_count_next      = r_count;
      w_game_reset_next = 1'b0;
      w_steer           = decode_steer(r_code_d1, w_is_ext);
      w_steer_ok        = 1'b0;

      if (w_is_make) begin
         if (!w_is_ext && is_game_key(r_code_d1)) begin
            w_dir_next[0] = DEFAULT_DIR1;
            w_dir_next[1] = DEFAULT_DIR2;
            w_dir_next[2] = DEFAULT_DIR3;
            w_dir_next[3] = DEFAULT_DIR4;
            case (r_code_d1)
               KEY_GAME_2P: w_count_next = 3'd2;
               KEY_GAME_3P: w_count_next = 3'd3;
               KEY_GAME_4P: w_count_next = 3'd4;
               default:     w_count_next = r_count;
            endcase
         end

         // A reversal would make the snake run into itself; it is refused when disallowed.
         w_steer_ok = w_steer.valid &&
                      player_active(w_steer.player, r_count) &&
                      ((ALLOW_REVERSE != 0) ||
                       (w_steer.dir != opposite_dir(r_dir[w_steer.player])));
         if (w_steer_ok) begin
            w_dir_next[w_steer.player] = w_steer.dir;
         end
      end

      if (w_is_break && !w_is_ext && is_game_key(r_code_d1)) begin
         w_game_reset_next = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_dir[0]     <= DEFAULT_DIR1;
         r_dir[1]     <= DEFAULT_DIR2;
         r_dir[2]     <= DEFAULT_DIR3;
         r_dir[3]     <= DEFAULT_DIR4;
         r_count      <= DEFAULT_PLAYER_COUNT;
         r_game_reset <= 1'b0;
      end else begin
         for (int p = 0; p < 4; p++) begin
            r_dir[p] <= w_dir_next[p];
         end
         r_count      <= w_count_next;
         r_game_reset <= w_game_reset_next;
      end
   end

   assign ps2_bus.dir1         = r_dir[0];
   assign ps2_bus.dir2         = r_dir[1];
   assign ps2_bus.dir3         = r_dir[2];
   assign ps2_bus.dir4         = r_dir[3];
   assign ps2_bus.player_count = r_count;
   assign ps2_bus.game_reset   = r_game_reset;

endmodule
`default_nettype wire

// File: tb/tb_ps2_command_decoder.sv
`default_nettype none
// tb_ps2_command_decoder: directed scancode sequences against a key-table model, two
// decoder instances (reversal allowed / refused) checked every cycle.
module tb_ps2_command_decoder;
   import tron_types::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tb_new;
   logic [7:0] tb_code;

   always #5 clk = ~clk;

   ps2_command_decoder_if bus_a ();
   ps2_command_decoder_if bus_b ();

   assign bus_a.ps2_code_new = tb_new;
   assign bus_a.ps2_code     = tb_code;
   assign bus_b.ps2_code_new = tb_new;
   assign bus_b.ps2_code     = tb_code;

   ps2_command_decoder #(.ALLOW_REVERSE(1)) u_dut_a (
      .clock   (clk),
      .reset_n (rst_n),
      .ps2_bus (bus_a.slave)
   );

   ps2_command_decoder #(.ALLOW_REVERSE(0)) u_dut_b (
      .clock   (clk),
      .reset_n (rst_n),
      .ps2_bus (bus_b.slave)
   );

   int total = 0;
   int bad   = 0;

   // Model: m_dir holds an index into UP,DOWN,LEFT,RIGHT (key-table column order).
   int  DIRS    [4]    = '{int'(DIR_UP), int'(DIR_DOWN), int'(DIR_LEFT), int'(DIR_RIGHT)};
   int  OPP_IDX [4]    = '{1, 0, 3, 2};
   int  NEED    [4]    = '{0, 0, 3, 4};
   int  KEYS    [4][4] = '{'{'h1D, 'h1B, 'h1C, 'h23},
                           '{'h75, 'h72, 'h6B, 'h74},
                           '{'h2C, 'h34, 'h2B, 'h33},
                           '{'h43, 'h42, 'h3B, 'h4B}};
   int  m_dir   [2][4];
   int  m_cnt   [2];
   int  m_grst;
   bit  m_ext;
   bit  m_brk;
   int  cycle = 0;

   typedef struct { int b; int at; } ev_t;
   ev_t evq [$];
   ev_t ev_cur;

   task automatic cmp(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_dir[i][0] = 3;
         m_dir[i][1] = 2;
         m_dir[i][2] = 1;
         m_dir[i][3] = 0;
         m_cnt[i]    = 4;
      end
      m_grst = 0;
      m_ext  = 0;
      m_brk  = 0;
      evq.delete();
   endtask

   task automatic model_make(input int i, input int b, input bit ext);
      bit game_key;
      game_key = (b == 'h1E) || (b == 'h26) || (b == 'h25) || (b == 'h29);
      if (!ext && game_key) begin
         if (b == 'h1E) m_cnt[i] = 2;
         if (b == 'h26) m_cnt[i] = 3;
         if (b == 'h25) m_cnt[i] = 4;
         m_dir[i][0] = 3;
         m_dir[i][1] = 2;
         m_dir[i][2] = 1;
         m_dir[i][3] = 0;
      end
      for (int p = 0; p < 4; p++) begin
         for (int d = 0; d < 4; d++) begin
            if (KEYS[p][d] == b && ((p == 1) == ext) && m_cnt[i] >= NEED[p]) begin
               if (i == 0 || d != OPP_IDX[m_dir[i][p]]) m_dir[i][p] = d;
            end
         end
      end
   endtask

   task automatic model_byte(input int b);
      if (b == 'hE0) begin
         m_ext = 1;
      end else if (b == 'hF0) begin
         m_brk = 1;
      end else begin
         if (!m_brk) begin
            for (int i = 0; i < 2; i++) model_make(i, b, m_ext);
         end else if (!m_ext && (b == 'h29 || b == 'h1E || b == 'h26 || b == 'h25)) begin
            m_grst = 1;
         end
         m_ext = 0;
         m_brk = 0;
      end
   endtask

   // A rise first sampled at the next edge takes effect on the edge after that.
   always @(posedge clk) begin
      cycle++;
      m_grst = 0;
      while (evq.size() > 0 && evq[0].at <= cycle) begin
         ev_cur = evq.pop_front();
         if (ev_cur.at == cycle) model_byte(ev_cur.b);
      end
   end

   always @(negedge clk) begin
      cmp("A.dir1", int'(bus_a.dir1), DIRS[m_dir[0][0]]);
      cmp("A.dir2", int'(bus_a.dir2), DIRS[m_dir[0][1]]);
      cmp("A.dir3", int'(bus_a.dir3), DIRS[m_dir[0][2]]);
      cmp("A.dir4", int'(bus_a.dir4), DIRS[m_dir[0][3]]);
      cmp("A.player_count", int'(bus_a.player_count), m_cnt[0]);
      cmp("A.game_reset", int'(bus_a.game_reset), m_grst);
      cmp("B.dir1", int'(bus_b.dir1), DIRS[m_dir[1][0]]);
      cmp("B.dir2", int'(bus_b.dir2), DIRS[m_dir[1][1]]);
      cmp("B.dir3", int'(bus_b.dir3), DIRS[m_dir[1][2]]);
      cmp("B.dir4", int'(bus_b.dir4), DIRS[m_dir[1][3]]);
      cmp("B.player_count", int'(bus_b.player_count), m_cnt[1]);
      cmp("B.game_reset", int'(bus_b.game_reset), m_grst);
   end

   task automatic raise(input logic [7:0] b);
      @(negedge clk);
      tb_new  = 1'b1;
      tb_code = b;
      evq.push_back('{b: int'(b), at: cycle + 2});
   endtask

   task automatic lower();
      @(negedge clk);
      tb_new = 1'b0;
   endtask

   // Returns on the falling edge just after the byte's effect is visible.
   task automatic send(input logic [7:0] b);
      raise(b);
      lower();
      lower();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      tb_new  = 1'b0;
      tb_code = 8'h00;
      model_reset();
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      cmp("reset dir1", int'(bus_a.dir1), int'(DIR_RIGHT));
      cmp("reset dir2", int'(bus_a.dir2), int'(DIR_LEFT));
      cmp("reset dir3", int'(bus_a.dir3), int'(DIR_DOWN));
      cmp("reset dir4", int'(bus_a.dir4), int'(DIR_UP));
      cmp("reset player_count", int'(bus_a.player_count), 4);
      cmp("reset game_reset", int'(bus_a.game_reset), 0);

      // Latency: unchanged one edge after the rise, updated on the second.
      raise(8'h1D);
      lower();
      cmp("1D after 1 edge", int'(bus_a.dir1), int'(DIR_RIGHT));
      lower();
      cmp("1D after 2 edges", int'(bus_a.dir1), int'(DIR_UP));
      cmp("1D B dir1", int'(bus_b.dir1), int'(DIR_UP));
      cmp("1D dir2 untouched", int'(bus_a.dir2), int'(DIR_LEFT));

      send(8'h5A);
      cmp("unmapped 5A", int'(bus_a.dir1), int'(DIR_UP));

      send(8'hE0); send(8'h75);
      cmp("E0 75 dir2", int'(bus_a.dir2), int'(DIR_UP));
      send(8'hE0); send(8'h6B);
      cmp("E0 6B dir2", int'(bus_a.dir2), int'(DIR_LEFT));
      send(8'hE0); send(8'hF0); send(8'h6B);
      send(8'hE0); send(8'h75);
      send(8'hE0); send(8'hF0); send(8'h6B);
      cmp("E0 F0 6B no change", int'(bus_a.dir2), int'(DIR_UP));
      send(8'h6B);
      cmp("bare 6B ignored", int'(bus_a.dir2), int'(DIR_UP));
      send(8'hF0); send(8'hE0); send(8'h72);
      cmp("F0 E0 72 no change", int'(bus_a.dir2), int'(DIR_UP));
      send(8'hE0); send(8'h72);
      cmp("E0 72 A dir2", int'(bus_a.dir2), int'(DIR_DOWN));
      cmp("E0 72 B reverse refused", int'(bus_b.dir2), int'(DIR_UP));

      send(8'h1E);
      cmp("1E count", int'(bus_a.player_count), 2);
      cmp("1E dir2 default", int'(bus_a.dir2), int'(DIR_LEFT));
      send(8'hF0); send(8'h1E);
      cmp("F0 1E pulse", int'(bus_a.game_reset), 1);
      @(negedge clk);
      cmp("F0 1E pulse ends", int'(bus_a.game_reset), 0);
      send(8'h2C);
      cmp("P3 ignored at 2", int'(bus_a.dir3), int'(DIR_DOWN));

      send(8'h26); send(8'h2C);
      cmp("P3 at 3 A", int'(bus_a.dir3), int'(DIR_UP));
      cmp("P3 at 3 B reverse", int'(bus_b.dir3), int'(DIR_DOWN));
      send(8'h42);
      cmp("P4 ignored at 3", int'(bus_a.dir4), int'(DIR_UP));
      send(8'h25); send(8'h42);
      cmp("P4 at 4 A", int'(bus_a.dir4), int'(DIR_DOWN));
      cmp("P4 at 4 B reverse", int'(bus_b.dir4), int'(DIR_UP));

      send(8'h1C);
      cmp("1C A dir1", int'(bus_a.dir1), int'(DIR_LEFT));
      cmp("1C B stays", int'(bus_b.dir1), int'(DIR_RIGHT));
      send(8'h1D);
      cmp("1D B dir1", int'(bus_b.dir1), int'(DIR_UP));
      send(8'h1D);
      send(8'hE0); send(8'h1B);
      cmp("P1 with ext ignored", int'(bus_a.dir1), int'(DIR_UP));

      send(8'h26); send(8'h1D); send(8'h29);
      cmp("29 defaults", int'(bus_a.dir1), int'(DIR_RIGHT));
      cmp("29 count kept", int'(bus_a.player_count), 3);
      send(8'hE0); send(8'hF0); send(8'h29);
      send(8'hF0); send(8'h29);
      cmp("F0 29 pulse", int'(bus_a.game_reset), 1);
      send(8'hF0); send(8'h1D);

      // Long hold is a single event.
      send(8'h1D);
      raise(8'h23);
      repeat (50) @(negedge clk);
      lower(); lower();
      cmp("held 23 dir1", int'(bus_a.dir1), int'(DIR_RIGHT));
      send(8'hF0);
      raise(8'h1E);
      repeat (50) @(negedge clk);
      lower(); lower();
      cmp("held F0 1E count", int'(bus_a.player_count), 3);

      send(8'hE0);
      do_reset();
      send(8'h74);
      cmp("reset drops E0", int'(bus_a.dir2), int'(DIR_LEFT));

      @(negedge clk);
      tb_new  = 1'b1;
      tb_code = 8'h1D;
      do_reset();
      repeat (5) @(negedge clk);
      cmp("high at release", int'(bus_a.dir1), int'(DIR_RIGHT));
      lower(); lower();
      send(8'h1D);
      cmp("1D after reset", int'(bus_a.dir1), int'(DIR_UP));

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
